// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: active-low segment patterns
// ({g,f,e,d,c,b,a}) and prescaler sizing.
`timescale 1ns/1ps

package seven_segment_scanner_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Clocks per digit slot; never below one so tiny clock ratios still scan.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned refresh_hz,
                                             input int unsigned digits);
        int unsigned div;
        div = clk_hz / (refresh_hz * digits);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern ({g,f,e,d,c,b,a}).
`timescale 1ns/1ps

module hex_to_seg
    import seven_segment_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode hex display driver with frame-synchronous value commit.
// Optional leading-zero blanking: define SEG_LEAD_ZERO_BLANK_EN.
`timescale 1ns/1ps

module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned DIGITS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic                  pending,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int unsigned DIV    = calc_div(CLK_HZ, REFRESH_HZ, DIGITS);
    localparam int          CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          DATA_W = 4 * DIGITS;

    localparam logic [DIGITS-1:0] AN_OFF   = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic              tick;
    logic              commit;
    logic [DATA_W-1:0] shadow_data;
    logic [DATA_W-1:0] active_data;
    logic [DATA_W-1:0] show_data;
    logic [DIGITS-1:0] shadow_mask;
    logic [DIGITS-1:0] active_mask;
    logic [DIGITS-1:0] commit_mask;
    logic [DIGITS-1:0] show_mask;
    logic [3:0]        show_nibble;
    logic [6:0]        decoded;

    assign tick     = (presc == CNT_LAST);
    assign commit   = tick && (idx == IDX_LAST) && pending;
    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

`ifdef SEG_LEAD_ZERO_BLANK_EN
    // Darken zero digits from the top down to the first nonzero one; digit 0 always shows.
    logic leading;
    always_comb begin
        commit_mask = shadow_mask;
        leading     = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (leading && (shadow_data[4*i +: 4] == 4'h0)) begin
                commit_mask[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign commit_mask = shadow_mask;
`endif

    // At a frame boundary the first digit of the new frame already comes from the shadow.
    assign show_data   = commit ? shadow_data : active_data;
    assign show_mask   = commit ? commit_mask : active_mask;
    assign show_nibble = 4'(show_data >> {idx_next, 2'b00});

    hex_to_seg u_hex_to_seg (
        .nibble (show_nibble),
        .seg    (decoded)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx_next;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load coinciding with a commit refills the shadow, so pending stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_data <= '0;
            shadow_mask <= '0;
            active_data <= '0;
            active_mask <= '0;
            pending     <= 1'b0;
        end else begin
            if (commit) begin
                active_data <= shadow_data;
                active_mask <= commit_mask;
            end
            if (load) begin
                shadow_data <= data;
                shadow_mask <= blank_mask;
                pending     <= 1'b1;
            end else if (commit) begin
                pending     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (tick) begin
            if (show_mask[idx_next]) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end else begin
                an  <= ~(DIGITS'(1) << idx_next);
                seg <= decoded;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized self-checking bench for seven_segment_scanner against a frame-level model.
// Honours SEG_LEAD_ZERO_BLANK_EN the same way the design does.
`timescale 1ns/1ps

module tb_seven_segment_scanner;

    localparam int unsigned CLK_HZ     = 8;
    localparam int unsigned REFRESH_HZ = 1;
    localparam int unsigned DIGITS     = 4;
    localparam int          DIV        = 2;
    localparam int          FRAME      = DIV * DIGITS;

    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  blank_mask = '0;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model state: edges since reset release, shadow/active value, expected outputs.
    int          edge_n = 0;
    int          new_idx;
    bit          is_tick;
    logic [15:0] m_shadow_data, m_active_data;
    logic [3:0]  m_shadow_mask, m_active_mask;
    bit          m_pending;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    seven_segment_scanner #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .DIGITS     (DIGITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .blank_mask (blank_mask),
        .pending    (pending),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] lead_blank(input logic [15:0] v);
        logic [3:0] m;
        int top;
        m = '0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        top = 0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) top = i;
        for (int i = 1; i < 4; i++) if (i > top) m[i] = 1'b1;
`else
        top = 0;
`endif
        return m;
    endfunction

    task automatic model_reset();
        edge_n        = 0;
        m_shadow_data = '0;
        m_active_data = '0;
        m_shadow_mask = '0;
        m_active_mask = '0;
        m_pending     = 1'b0;
        exp_an        = 4'hF;
        exp_seg       = 7'h7F;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            edge_n++;
            is_tick = (edge_n % DIV) == 0;
            new_idx = (edge_n / DIV) % DIGITS;
            if (is_tick && new_idx == 0 && m_pending) begin
                m_active_data = m_shadow_data;
                m_active_mask = m_shadow_mask | lead_blank(m_shadow_data);
                m_pending     = 1'b0;
            end
            if (load) begin
                m_shadow_data = data;
                m_shadow_mask = blank_mask;
                m_pending     = 1'b1;
            end
            if (is_tick) begin
                if (m_active_mask[new_idx]) begin
                    exp_an  = 4'hF;
                    exp_seg = 7'h7F;
                end else begin
                    exp_an  = ~(4'b0001 << new_idx);
                    exp_seg = HEX_TABLE[m_active_data[4*new_idx +: 4]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && check_en) begin
            checkOutput("an", 32'(an), 32'(exp_an));
            checkOutput("seg", 32'(seg), 32'(exp_seg));
            checkOutput("pending", 32'(pending), 32'(m_pending));
        end
    end

    // Caller sits just after a falling edge; load is seen on the next rising edge only.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m);
        load       = 1'b1;
        data       = d;
        blank_mask = m;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((edge_n % FRAME) != p && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if ((edge_n % FRAME) != p) begin
            total++;
            bad++;
            $display("[TB] FAIL phase_wait: got %0d expected %0d", edge_n % FRAME, p);
        end
    endtask

    task automatic mid_scan_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("rst_an", 32'(an), 32'h0000000F);
        checkOutput("rst_seg", 32'(seg), 32'h0000007F);
        checkOutput("rst_pending", 32'(pending), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #1;
        checkOutput("init_an", 32'(an), 32'h0000000F);
        checkOutput("init_seg", 32'(seg), 32'h0000007F);
        checkOutput("init_pending", 32'(pending), 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        run_cycles(5);
        applyStimulus(16'h12AF, 4'b0000);
        run_cycles(3 * FRAME);

        wait_phase(0);
        applyStimulus(16'h1111, 4'b0000);
        run_cycles(2);
        applyStimulus(16'h2222, 4'b0000);
        run_cycles(2 * FRAME);

        wait_phase(0);
        applyStimulus(16'h0003, 4'b0000);
        wait_phase(7);
        applyStimulus(16'h5A5A, 4'b0000);
        run_cycles(3 * FRAME);

        applyStimulus(16'h4321, 4'b1010);
        run_cycles(3 * FRAME);

        applyStimulus(16'h0050, 4'b0000);
        run_cycles(2 * FRAME);
        applyStimulus(16'h0000, 4'b0000);
        run_cycles(2 * FRAME);

        mid_scan_reset();
        run_cycles(3);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(16'($urandom),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
            run_cycles($urandom_range(0, 14));
            if (i == 30) begin
                mid_scan_reset();
                run_cycles(2);
            end
        end
        run_cycles(3 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
